// File: rtl/wrr_fifo_scheduler.sv
// Weighted round-robin read scheduler for four downstream 8-bit FIFOs.
// Mirrors each FIFO's occupancy from its write/read strobes, issues one
// read strobe per cycle to the queue being served, and spends a per-queue
// credit (reloaded from that queue's weight) before moving to the next
// non-empty queue.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | every queue empty, no reads issued
//   ST_SERVE | serving queue r_ptr, r_credit reads left in this burst
module wrr_fifo_scheduler #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] wen,
  input  logic       out_ready,
  input  logic       cfg_we,
  input  logic [1:0] cfg_sel,
  input  logic [2:0] cfg_weight,
  output logic [3:0] ren,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic [3:0] full,
  output logic [3:0] overflow,
  output logic       busy
);

  typedef enum logic {ST_IDLE, ST_SERVE} state_t;

  localparam logic [3:0] LP_DEPTH = 4'(DEPTH);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [2:0] r_credit;
  logic [3:0] r_occ [4];
  logic [2:0] r_weight [4];
  logic [3:0] r_overflow;
  logic       r_grant_valid;
  logic [1:0] r_grant_id;

  logic [3:0] w_ren;
  logic [3:0] w_full;
  logic [3:0] w_acc;
  logic [3:0] w_drop;
  logic [3:0] w_ne_cur;
  logic [3:0] w_ne_nxt;
  logic [3:0] w_occ_nxt [4];
  logic       w_issue;
  logic       w_adv;
  logic [1:0] w_sel_ptr;

  // First non-empty queue searching ptr+1, ptr+2, ptr+3 and finally ptr itself.
  function automatic logic [1:0] f_next(input logic [1:0] ptr, input logic [3:0] ne);
    logic [1:0] sel;
    sel = ptr;
    for (int k = 4; k >= 1; k--) begin
      if (ne[ptr + 2'(k)]) sel = ptr + 2'(k);
    end
    return sel;
  endfunction

  // A stored weight of zero still grants one read per turn.
  function automatic logic [2:0] f_eff(input logic [2:0] w);
    return (w == 3'd0) ? 3'd1 : w;
  endfunction

  // Read issue, write acceptance and next-cycle occupancy per queue.
  always_comb begin
    w_issue  = (r_state == ST_SERVE) && out_ready && (r_occ[r_ptr] != 4'd0);
    w_ren    = '0;
    w_full   = '0;
    w_acc    = '0;
    w_drop   = '0;
    w_ne_cur = '0;
    w_ne_nxt = '0;
    for (int i = 0; i < 4; i++) begin
      w_ren[i]     = w_issue && (r_ptr == 2'(i));
      w_full[i]    = (r_occ[i] == LP_DEPTH);
      // A full queue still takes the write when it is read the same cycle.
      w_acc[i]     = wen[i] && (!w_full[i] || w_ren[i]);
      w_drop[i]    = wen[i] && w_full[i] && !w_ren[i];
      w_occ_nxt[i] = r_occ[i] + {3'b000, w_acc[i]} - {3'b000, w_ren[i]};
      w_ne_cur[i]  = (r_occ[i] != 4'd0);
      w_ne_nxt[i]  = (w_occ_nxt[i] != 4'd0);
    end
    w_adv     = w_issue && ((r_credit <= 3'd1) || !w_ne_nxt[r_ptr]);
    w_sel_ptr = (r_state == ST_IDLE) ? f_next(r_ptr, w_ne_cur) : f_next(r_ptr, w_ne_nxt);
  end

  // Occupancy mirrors, sticky overflow flags and weight registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_occ[i]    <= 4'd0;
        r_weight[i] <= 3'd1;
      end
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_occ[i] <= w_occ_nxt[i];
      end
      r_overflow <= r_overflow | w_drop;
      if (cfg_we) r_weight[cfg_sel] <= cfg_weight;
    end
  end

  // Grant reporting lines up with the FIFO's registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_valid <= 1'b0;
      r_grant_id    <= 2'd0;
    end else begin
      r_grant_valid <= w_issue;
      r_grant_id    <= w_issue ? r_ptr : 2'd0;
    end
  end

  // Scheduler FSM: pointer and credit only move on an issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 2'd3;
      r_credit <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_ne_cur) begin
            r_state  <= ST_SERVE;
            r_ptr    <= w_sel_ptr;
            r_credit <= f_eff(r_weight[w_sel_ptr]);
          end
        end
        ST_SERVE: begin
          if (w_issue) begin
            if (w_adv) begin
              if (|w_ne_nxt) begin
                r_ptr    <= w_sel_ptr;
                r_credit <= f_eff(r_weight[w_sel_ptr]);
              end else begin
                r_state  <= ST_IDLE;
                r_credit <= 3'd0;
              end
            end else begin
              r_credit <= r_credit - 3'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ren         = w_ren;
  assign full        = w_full;
  assign overflow    = r_overflow;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state == ST_SERVE);

endmodule

// File: tb/tb_wrr_fifo_scheduler.sv
// Bench for wrr_fifo_scheduler: directed weight/overflow/reset scenarios
// followed by random traffic, all compared cycle by cycle against a
// queue-level reference model.
module tb_wrr_fifo_scheduler;

  localparam int DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] wen;
  logic       out_ready;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [2:0] cfg_weight;
  logic [3:0] ren;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] full;
  logic [3:0] overflow;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: queue depths, weights, current burst owner and credit left
  int         m_occ [4];
  int         m_wt  [4];
  bit         m_ovf [4];
  bit         m_serve;
  int         m_cur;
  int         m_cred;
  bit         m_gv;
  logic [1:0] m_gid;

  int glog  [$];
  int exp_q [$];

  wrr_fifo_scheduler #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .out_ready  (out_ready),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_weight (cfg_weight),
    .ren        (ren),
    .grant_valid(grant_valid),
    .grant_id   (grant_id),
    .full       (full),
    .overflow   (overflow),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int eff(input int w);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int nextq(input int cur, input int occ [4]);
    for (int k = 1; k <= 4; k++) begin
      if (occ[(cur + k) % 4] > 0) return (cur + k) % 4;
    end
    return cur;
  endfunction

  function automatic bit any_ne(input int occ [4]);
    return (occ[0] > 0) || (occ[1] > 0) || (occ[2] > 0) || (occ[3] > 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_occ[i] = 0;
      m_wt[i]  = 1;
      m_ovf[i] = 1'b0;
    end
    m_serve = 1'b0;
    m_cur   = 3;
    m_cred  = 0;
    m_gv    = 1'b0;
    m_gid   = 2'd0;
  endtask

  // One clock cycle: drive inputs, check all outputs, then advance the model
  task automatic step(input logic [3:0] w, input logic rdy,
                      input logic cwe = 1'b0, input logic [1:0] csel = 2'd0,
                      input logic [2:0] cwt = 3'd0);
    logic [3:0] e_ren;
    logic [3:0] e_full;
    logic [3:0] e_ovf;
    int         occ_old [4];
    @(negedge clk);
    wen = w; out_ready = rdy; cfg_we = cwe; cfg_sel = csel; cfg_weight = cwt;
    #1;
    e_ren = (m_serve && rdy && m_occ[m_cur] > 0) ? (4'b0001 << m_cur) : 4'b0000;
    for (int i = 0; i < 4; i++) begin
      e_full[i] = (m_occ[i] == DEPTH);
      e_ovf[i]  = m_ovf[i];
    end
    chk("ren", ren, e_ren);
    chk("busy", busy, m_serve);
    chk("full", full, e_full);
    chk("overflow", overflow, e_ovf);
    chk("grant", {grant_valid, grant_valid ? grant_id : 2'b00},
                 {m_gv, m_gv ? m_gid : 2'b00});
    if (grant_valid) glog.push_back(int'(grant_id));

    occ_old = m_occ;
    for (int i = 0; i < 4; i++) begin
      if (w[i]) begin
        if (m_occ[i] < DEPTH || e_ren[i]) m_occ[i]++;
        else m_ovf[i] = 1'b1;
      end
      if (e_ren[i]) m_occ[i]--;
    end
    m_gv  = (e_ren != 4'b0000);
    m_gid = m_gv ? 2'(m_cur) : 2'd0;
    if (!m_serve) begin
      if (any_ne(occ_old)) begin
        m_cur   = nextq(m_cur, occ_old);
        m_cred  = eff(m_wt[m_cur]);
        m_serve = 1'b1;
      end
    end else if (e_ren != 4'b0000) begin
      m_cred--;
      if (m_cred == 0 || m_occ[m_cur] == 0) begin
        if (any_ne(m_occ)) begin
          m_cur  = nextq(m_cur, m_occ);
          m_cred = eff(m_wt[m_cur]);
        end else begin
          m_serve = 1'b0;
        end
      end
    end
    if (cwe) m_wt[csel] = int'(cwt);
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once
  task automatic do_reset();
    @(negedge clk);
    wen = '0; out_ready = 1'b0; cfg_we = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ren", ren, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gvalid", grant_valid, 1'b0);
    chk("rst_gid", grant_id, 2'd0);
    chk("rst_full", full, 4'b0000);
    chk("rst_ovf", overflow, 4'b0000);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, glog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < glog.size(); i++) begin
      chk(tag, glog[i], exp_q[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0; wen = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_weight = '0;
    model_reset();
    #3;
    chk("por_busy", busy, 1'b0);
    chk("por_ren", ren, 4'b0000);
    #9;
    rst_n = 1'b1;
    step(4'b0000, 1'b1);

    // equal weights: two words per queue, strict rotation
    repeat (2) step(4'b1111, 1'b0);
    glog.delete();
    repeat (12) step(4'b0000, 1'b1);
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    chk_seq("seq_equal");
    chk("idle_after_equal", busy, 1'b0);

    // q0 weight 3 vs q1 weight 1
    step(4'b0000, 1'b0, 1'b1, 2'd0, 3'd3);
    repeat (5) step(4'b0011, 1'b0);
    glog.delete();
    repeat (14) step(4'b0000, 1'b1);
    exp_q = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 1};
    chk_seq("seq_weighted");

    // sink stalls for three cycles in the middle of a q0 burst
    repeat (2) step(4'b0011, 1'b0);
    repeat (2) step(4'b0001, 1'b0);
    glog.delete();
    step(4'b0000, 1'b1);
    repeat (3) step(4'b0000, 1'b0);
    repeat (8) step(4'b0000, 1'b1);
    exp_q = '{0, 0, 0, 1, 0, 1};
    chk_seq("seq_stall");

    // fill q2 with no reads, then one write too many
    repeat (8) step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    chk("full2_after8", full[2], 1'b1);
    chk("ovf2_after8", overflow[2], 1'b0);
    step(4'b0000, 1'b0);
    chk("ovf2_after9", overflow[2], 1'b1);
    chk("full2_after9", full[2], 1'b1);

    // reset while serving; first grant afterwards is queue 0
    chk("busy_before_rst", busy, 1'b1);
    do_reset();
    step(4'b1001, 1'b0);
    glog.delete();
    repeat (6) step(4'b0000, 1'b1);
    exp_q = '{0, 3};
    chk_seq("seq_after_rst");

    // write and read a full queue in the same cycle
    repeat (8) step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b0);
    chk("full1_wr_rd", full[1], 1'b1);
    chk("ovf1_wr_rd", overflow[1], 1'b0);
    repeat (12) step(4'b0000, 1'b1);

    // random traffic, weight changes and one reset in the middle
    for (int n = 0; n < 600; n++) begin
      logic [3:0] rw;
      logic       rr;
      logic       rc;
      rw = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 7) == 0);
      step(rw, rr, rc, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      if (n == 300) do_reset();
    end
    repeat (40) step(4'b0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
